// File: rtl/frame_packer_pkg.sv
// Shared definitions for the frame packer: default geometry, packed frame
// size and the controller state encoding.
package frame_packer_pkg;

  localparam int unsigned DEF_IMG_W  = 32;
  localparam int unsigned DEF_IMG_H  = 32;
  localparam int unsigned DEF_PIX_W  = 8;
  localparam int unsigned FRAME_BITS = DEF_IMG_W * DEF_IMG_H * DEF_PIX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_START,
    ST_BUSY
  } state_e;

endpackage

// File: rtl/frame_packer.sv
// Frame packer: collects a raster-order pixel stream into a full frame
// register, pulses cnn_start once the last pixel lands, then holds the
// frame stable until the CNN reports completion.
module frame_packer
  import frame_packer_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned PIX_W = DEF_PIX_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [PIX_W-1:0]               pix_data,
  input  logic                           pix_sof,
  output logic [IMG_W*IMG_H*PIX_W-1:0]   frame_data,
  output logic                           cnn_start,
  input  logic                           cnn_done,
  output logic                           busy,
  output logic                           sof_err,
  output logic [15:0]                    frame_cnt
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               sof_err_q, sof_err_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [PIX_W-1:0]   pix_mem_q [NPIX];

  logic               accept;
  logic               wr_en;
  logic [CNT_W-1:0]   wr_idx;
  logic [PIX_W-1:0]   wr_data;

  // Next-state, pixel write port and handshake outputs.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    sof_err_d   = sof_err_q;
    frame_cnt_d = frame_cnt_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_data     = pix_data;
    cnn_start   = 1'b0;
    pix_ready   = (state_q == ST_IDLE) || (state_q == ST_FILL);
    accept      = pix_valid && pix_ready;

    case (state_q)
      ST_IDLE: begin
        // Pixels without SOF are dropped until a frame begins.
        if (accept && pix_sof) begin
          wr_en     = 1'b1;
          wr_idx    = '0;
          pix_cnt_d = CNT_W'(1);
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (pix_sof) begin
            // Premature SOF: abandon the partial frame and restart.
            wr_idx    = '0;
            pix_cnt_d = CNT_W'(1);
            sof_err_d = 1'b1;
          end else begin
            wr_idx = pix_cnt_q;
            if (pix_cnt_q == LAST_IDX) begin
              pix_cnt_d = '0;
              state_d   = ST_START;
            end else begin
              pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_START: begin
        cnn_start   = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnn_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and frame storage; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      sof_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      for (int unsigned i = 0; i < NPIX; i++) pix_mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      sof_err_q   <= sof_err_d;
      frame_cnt_q <= frame_cnt_d;
      if (wr_en) pix_mem_q[wr_idx] <= wr_data;
    end
  end

  // Flatten the pixel array into the packed frame bus, index 0 at the LSBs.
  always_comb begin
    frame_data = '0;
    for (int unsigned i = 0; i < NPIX; i++) frame_data[i*PIX_W +: PIX_W] = pix_mem_q[i];
  end

  assign busy      = (state_q != ST_IDLE);
  assign sof_err   = sof_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: full frames, gapped streams, dropped
// pre-SOF pixels, premature SOF, BUSY hold behaviour and mid-frame reset.
module tb_frame_packer;
  import frame_packer_pkg::*;

  localparam int NPIX = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [7:0]            pix_data;
  logic                  pix_sof;
  logic [FRAME_BITS-1:0] frame_data;
  logic                  cnn_start;
  logic                  cnn_done;
  logic                  busy;
  logic                  sof_err;
  logic [15:0]           frame_cnt;

  frame_packer #(.IMG_W(32), .IMG_H(32), .PIX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .frame_data(frame_data),
    .cnn_start (cnn_start),
    .cnn_done  (cnn_done),
    .busy      (busy),
    .sof_err   (sof_err),
    .frame_cnt (frame_cnt)
  );

  int pass_cnt   = 0;
  int fail_cnt   = 0;
  int chk_cnt    = 0;
  int start_cnt  = 0;
  int starts_exp = 0;
  logic [FRAME_BITS-1:0] exp_frame;

  // Count start pulses away from the active edge.
  always @(negedge clk) if (cnn_start) start_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int i, input int base);
    return 8'(((i / 32) + (i % 32) + base) % 256);
  endfunction

  task automatic build_exp(input int base);
    for (int i = 0; i < NPIX; i++) exp_frame[i*8 +: 8] = pix_val(i, base);
  endtask

  task automatic push(input logic [7:0] d, input logic sof, input bit gap);
    if (gap && ($urandom_range(0, 1) == 1)) tick();
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send(input int from, input int to, input int base, input bit gaps);
    for (int i = from; i <= to; i++) push(pix_val(i, base), (i == 0), gaps && (i != 0));
  endtask

  // Called right after the tick that accepted the last pixel.
  task automatic finish_frame(input string tag, input int exp_fcnt);
    chk({tag, "_start_lat"},  32'(cnn_start), 32'd1);
    chk({tag, "_no_early"},   32'(start_cnt), 32'(starts_exp));
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_rdy_start"},  32'(pix_ready), 32'd0);
    chk({tag, "_frame"},      32'(frame_data === exp_frame), 32'd1);
    chk({tag, "_fcnt_pre"},   32'(frame_cnt), 32'(exp_fcnt - 1));
    tick();
    cnn_done = 1'b0;
    starts_exp++;
    chk({tag, "_one_pulse"},  32'(start_cnt), 32'(starts_exp));
    chk({tag, "_start_low"},  32'(cnn_start), 32'd0);
    chk({tag, "_fcnt"},       32'(frame_cnt), 32'(exp_fcnt));
    chk({tag, "_busy"},       32'(busy), 32'd1);
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    pix_data  = 8'hC3;
    repeat (3) tick();
    chk({tag, "_rdy_busy"},   32'(pix_ready), 32'd0);
    chk({tag, "_hold"},       32'(frame_data === exp_frame), 32'd1);
    cnn_done = 1'b1;
    tick();
    cnn_done  = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    chk({tag, "_idle"},       32'(busy), 32'd0);
    chk({tag, "_rdy_idle"},   32'(pix_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_sof   = 1'b0;
    cnn_done  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rdy",   32'(pix_ready), 32'd1);
    chk("rst_start", 32'(cnn_start), 32'd0);
    chk("rst_err",   32'(sof_err), 32'd0);
    chk("rst_fcnt",  32'(frame_cnt), 32'd0);
    chk("rst_frame", 32'(frame_data === '0), 32'd1);

    // Frame A: continuous stream.
    build_exp(0);
    send(0, NPIX - 1, 0, 1'b0);
    chk("a_px0",    32'(frame_data[7:0]), 32'h00);
    chk("a_pxlast", 32'(frame_data[8191:8184]), 32'h3E);
    finish_frame("a", 1);

    // Frame B: SOF right after done, then 50% random gaps.
    send(0, NPIX - 1, 0, 1'b1);
    finish_frame("b", 2);

    // Frame C: stray pixels in IDLE are dropped; cnn_done held high throughout.
    cnn_done = 1'b1;
    for (int i = 0; i < 5; i++) push(8'hF0 + 8'(i), 1'b0, 1'b0);
    chk("c_drop_idle", 32'(busy), 32'd0);
    build_exp(8'h11);
    send(0, NPIX - 1, 8'h11, 1'b0);
    chk("c_px0", 32'(frame_data[7:0]), 32'h11);
    chk("c_err", 32'(sof_err), 32'd0);
    finish_frame("c", 3);

    // Frame D: premature SOF at index 300 restarts the frame.
    send(0, 299, 8'h22, 1'b0);
    chk("d_err_pre", 32'(sof_err), 32'd0);
    push(pix_val(0, 8'h33), 1'b1, 1'b0);
    chk("d_err",  32'(sof_err), 32'd1);
    chk("d_fill", 32'(busy), 32'd1);
    send(1, NPIX - 1, 8'h33, 1'b0);
    build_exp(8'h33);
    finish_frame("d", 4);

    // Reset at pixel index 700, with a valid pixel presented the same cycle.
    send(0, 699, 8'h44, 1'b0);
    pix_valid = 1'b1;
    pix_data  = pix_val(700, 8'h44);
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    pix_valid = 1'b0;
    chk("r_rdy",   32'(pix_ready), 32'd1);
    chk("r_busy",  32'(busy), 32'd0);
    chk("r_frame", 32'(frame_data === '0), 32'd1);
    chk("r_fcnt",  32'(frame_cnt), 32'd0);
    chk("r_err",   32'(sof_err), 32'd0);
    repeat (3) tick();
    chk("r_no_start", 32'(start_cnt), 32'(starts_exp));

    // Frame E: normal completion after reset.
    build_exp(8'h55);
    send(0, NPIX - 1, 8'h55, 1'b0);
    finish_frame("e", 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
